// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types, limits and helpers for the mem_responder block
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int WAIT_CYCLES_MAX = 15;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= (34'(depth) << 2));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// rtl/mem_resp_ram.sv - DEPTH x 32 array, one write port, one registered read port
module mem_resp_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register holds between enabled reads, so it is the responder's data output.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated memory responder; MEM_RESP_STATS_EN adds request counters
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Mem_Data,
  output logic        Mem_Ready,
  output logic        Mem_Error,
  output logic        Busy
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0] Read_count,
  output logic [15:0] Write_count,
  output logic [15:0] Error_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD =
    4'((WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  op_t           op_q, op_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rej_q, rej_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;
  logic          ram_we, ram_re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rej_d   = rej_q;
    case (state_q)
      IDLE: begin
        if (Mem_Read || Mem_Write) begin
          op_d    = Mem_Write ? OP_WRITE : OP_READ;
          idx_d   = Address[AW+1:2];
          wdata_d = Write_data;
          rej_d   = (Mem_Read && Mem_Write) || addr_err(Address, DEPTH);
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_LOAD == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == DONE);
    error_d = (state_d == DONE) && rej_d;
    busy_d  = (state_d != IDLE);
  end

  // Reads land on the edge entering DONE; writes commit on the edge leaving it.
  assign ram_re = (state_d == DONE) && (op_d == OP_READ) && !rej_d;
  assign ram_we = (state_q == DONE) && (op_q == OP_WRITE) && !rej_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rej_q   <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rej_q   <= rej_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  mem_resp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (Clock),
    .rst_n (Reset),
    .we    (ram_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .re    (ram_re),
    .raddr (idx_d),
    .rdata (Mem_Data)
  );

  assign Mem_Ready = ready_q;
  assign Mem_Error = error_q;
  assign Busy      = busy_q;

`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, er_cnt_q, er_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    er_cnt_d = er_cnt_q;
    if (state_q == DONE) begin
      if (rej_q)                 er_cnt_d = sat_inc(er_cnt_q);
      else if (op_q == OP_READ)  rd_cnt_d = sat_inc(rd_cnt_q);
      else                       wr_cnt_d = sat_inc(wr_cnt_q);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
      er_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      er_cnt_q <= er_cnt_d;
    end
  end

  assign Read_count  = rd_cnt_q;
  assign Write_count = wr_cnt_q;
  assign Error_count = er_cnt_q;
`endif

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder serving the multicycle MIPS core's memory strobes (Mem_Read / Mem_Write, Address, Write_data) with a registered, wait-stated reply (Mem_Data, Mem_Ready). It replaces the zero-latency memory model at the far end of the core's memory port, so the control unit can be exercised against realistic, variable-latency memory. Requests are latched on acceptance, served after a programmable number of wait states, and completed with a one-cycle ready pulse.

## Interface
- DEPTH, 256: number of 32-bit words stored; must be a power of two, ≥ 4.
- WAIT_CYCLES, 2: wait states between acceptance and Mem_Ready; range 0..15.
- Clock  in  1  rising-edge clock for all state.
- Reset  in  1  asynchronous, active-low reset; one clock domain only.
- Mem_Read  in  1  read request strobe.
- Mem_Write  in  1  write request strobe.
- Address  in  32  byte address; word index = Address[log2(DEPTH)+1:2].
- Write_data  in  32  write data.
- Mem_Data  out  32  read data; holds its value until the next successful read.
- Mem_Ready  out  1  one-cycle completion pulse.
- Mem_Error  out  1  valid with Mem_Ready; the request was rejected.
- Busy  out  1  high in WAIT and DONE.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if Mem_Read or Mem_Write is high at a rising edge, latch op, Address and Write_data, load the wait counter with WAIT_CYCLES, and go to WAIT. If WAIT_CYCLES = 0, go directly to DONE.
- WAIT: decrement the counter. When the counter reaches 1, go to DONE. Strobe and address changes are ignored.
- DONE: Mem_Ready = 1 for exactly one cycle.
  - Read: Mem_Data is updated with the word at the latched index on the edge entering DONE.
  - Write: the array is updated on the edge leaving DONE.
  - DONE → IDLE unconditionally.
- Error is flagged when any of these hold:
  - Mem_Read and Mem_Write are both high.
  - Address[1:0] ≠ 0.
  - Address ≥ DEPTH·4.
- On error, the request still completes with Mem_Ready and Mem_Error = 1. No array write occurs and Mem_Data is unchanged.
- Strobes held high across DONE are not re-accepted until the cycle after DONE (IDLE). The requester must drop its strobes upon Mem_Ready or a new request follows.
- Reset values:
  - State = IDLE; counter = 0.
  - Mem_Data = 0, Mem_Ready = 0, Mem_Error = 0, Busy = 0.
  - The array is not reset.
- Reset asserted mid-request: the transaction is aborted, no write occurs, and outputs take their reset values immediately (asynchronously).

## Timing
- Acceptance edge = cycle 0; Mem_Ready is high during cycle WAIT_CYCLES+1.
- Minimum request period is WAIT_CYCLES+2 cycles (one IDLE cycle between requests).
- A read issued the cycle after a write's DONE, to the same address, returns the new data.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MEM_RESP_STATS_EN defined:
  - Adds output ports Read_count[15:0], Write_count[15:0] and Error_count[15:0].
  - Each counter increments on its DONE cycle, saturates at 16'hFFFF, and resets to 0.
  - A rejected request increments only Error_count.
- MEM_RESP_STATS_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Package mem_resp_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the op enum (OP_READ, OP_WRITE);
  - the WAIT_CYCLES range limit constant;
  - the error-check function (alignment and range).
- Sub-module mem_resp_ram: a DEPTH×32 synchronous array with one write port and one registered read port. The FSM, wait counter and latches stay in mem_responder.

## Test plan
- WAIT_CYCLES=2: write 32'hDEADBEEF to 0x10, then read 0x10 → Mem_Ready at cycle 3 each time, Mem_Error=0, Mem_Data=32'hDEADBEEF.
- WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 → Mem_Ready one cycle after each acceptance; requests accepted every 2 cycles.
- Read of 0x13 (misaligned) and of DEPTH·4 (out of range) → Mem_Ready with Mem_Error=1; Mem_Data keeps its previous value.
- Mem_Read=Mem_Write=1 at 0x20 holding 32'h12345678 → Mem_Error=1; a subsequent read of 0x20 returns 32'h12345678.
- Reset driven low during WAIT of a write to 0x8 → Mem_Ready never pulses and outputs go to 0; a read of 0x8 after reset returns the old contents.
- MEM_RESP_STATS_EN: 3 reads, 2 writes, 1 error → Read_count=3, Write_count=2, Error_count=1.
